// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU result serializer: CTL error codes,
// packet type bit values, FSM state encoding and CTL classification.
package mtm_alu_pkg;

  localparam logic [7:0] ERR_OP   = 8'h93;
  localparam logic [7:0] ERR_DATA = 8'hC9;
  localparam logic [7:0] ERR_CRC  = 8'hA5;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CTL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    TYPE,
    PAYLOAD,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    CLS_DATA,
    CLS_ERROR,
    CLS_DROP
  } ctl_class_t;

  // A clear MSB marks a normal data result; a set MSB is only legal for the
  // three known error codes, anything else is discarded.
  function automatic ctl_class_t classify_ctl(input logic [7:0] ctl);
    ctl_class_t cls;
    if (!ctl[7]) begin
      cls = CLS_DATA;
    end else if (ctl == ERR_OP || ctl == ERR_DATA || ctl == ERR_CRC) begin
      cls = CLS_ERROR;
    end else begin
      cls = CLS_DROP;
    end
    return cls;
  endfunction

endpackage

// File: rtl/mtm_alu_bit_timer.sv
// Baud divider: while run is high, bit_tick fires on the last of every
// CLK_PER_BIT cycles. The count is held at zero when idle so every frame
// starts with a full-length first bit.
module mtm_alu_bit_timer #(
  parameter int CLK_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_tick
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  logic [CW-1:0] baud_cnt;

  // Count 0..CLK_PER_BIT-1 while running, wrapping on the tick.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      baud_cnt <= '0;
    end else if (baud_cnt == LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

  assign bit_tick = run && (baud_cnt == LAST);

endmodule

// File: rtl/mtm_alu_frame_serializer.sv
// Serializes an ALU result word plus its CTL byte into UART-style packets
// (start, type, 8 payload bits MSB first, stop bits) on a registered line.
module mtm_alu_frame_serializer
  import mtm_alu_pkg::*;
#(
  parameter int DATA_BYTES  = 4,
  parameter int STOP_BITS   = 1,
  parameter int CLK_PER_BIT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] C,
  input  logic [7:0]              CTL_out,
  output logic                    sout,
  output logic                    busy,
  output logic                    tx_done,
  output logic                    drop
);

  localparam int SRW = 8 * (DATA_BYTES + 1);
  localparam int PW  = $clog2(DATA_BYTES + 2);
  localparam int SW  = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);
  localparam logic [PW-1:0] DATA_PKTS = PW'(DATA_BYTES + 1);

  state_t          state, state_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [SW-1:0]   stop_cnt, stop_cnt_n;
  logic [PW-1:0]   pkt_cnt, pkt_cnt_n;
  logic [PW-1:0]   pkt_total, pkt_total_n;
  logic [SRW-1:0]  sreg, sreg_n;
  logic            sout_n;
  logic            drop_n;
  logic            armed;
  logic            bit_tick;
  logic            accept;
  logic            frame_end;
  ctl_class_t      ctl_class;

  mtm_alu_bit_timer #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (busy),
    .bit_tick (bit_tick)
  );

  assign busy      = (state != IDLE);
  assign frame_end = (state == STOP) && bit_tick && (stop_cnt == LAST_STOP) &&
                     (pkt_cnt == pkt_total - PW'(1));
  // Ready also during the final stop-bit cycle so a held in_valid chains
  // the next response with no idle bit in between.
  assign in_ready  = (armed && state == IDLE) || frame_end;
  assign tx_done   = frame_end;
  assign accept    = in_valid && in_ready;
  assign ctl_class = classify_ctl(CTL_out);

  // Next-state, counter, shift-register and next-line-level decode.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    stop_cnt_n  = stop_cnt;
    pkt_cnt_n   = pkt_cnt;
    pkt_total_n = pkt_total;
    sreg_n      = sreg;
    drop_n      = 1'b0;
    sout_n      = 1'b1;

    unique case (state)
      IDLE: ;
      START: begin
        if (bit_tick) state_n = TYPE;
      end
      TYPE: begin
        if (bit_tick) begin
          state_n   = PAYLOAD;
          bit_cnt_n = 3'd7;
        end
      end
      PAYLOAD: begin
        if (bit_tick) begin
          sreg_n = {sreg[SRW-2:0], 1'b0};
          if (bit_cnt == 3'd0) begin
            state_n    = STOP;
            stop_cnt_n = '0;
          end else begin
            bit_cnt_n = bit_cnt - 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_cnt == LAST_STOP) begin
            if (pkt_cnt == pkt_total - PW'(1)) begin
              state_n   = IDLE;
              pkt_cnt_n = '0;
            end else begin
              state_n   = START;
              pkt_cnt_n = pkt_cnt + PW'(1);
            end
          end else begin
            stop_cnt_n = stop_cnt + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      pkt_cnt_n = '0;
      unique case (ctl_class)
        CLS_DATA: begin
          state_n     = START;
          pkt_total_n = DATA_PKTS;
          sreg_n      = {C, CTL_out};
        end
        CLS_ERROR: begin
          state_n     = START;
          pkt_total_n = PW'(1);
          sreg_n      = {CTL_out, {(8*DATA_BYTES){1'b0}}};
        end
        default: begin
          state_n = IDLE;
          drop_n  = 1'b1;
        end
      endcase
    end

    unique case (state_n)
      START:   sout_n = 1'b0;
      TYPE:    sout_n = (pkt_cnt_n == pkt_total_n - PW'(1)) ? PKT_CTL : PKT_DATA;
      PAYLOAD: sout_n = sreg_n[SRW-1];
      default: sout_n = 1'b1;
    endcase
  end

  // State, counters and the registered serial line; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      pkt_cnt   <= '0;
      pkt_total <= '0;
      sreg      <= '0;
      sout      <= 1'b1;
      drop      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      stop_cnt  <= stop_cnt_n;
      pkt_cnt   <= pkt_cnt_n;
      pkt_total <= pkt_total_n;
      sreg      <= sreg_n;
      sout      <= sout_n;
      drop      <= drop_n;
      armed     <= 1'b1;
    end
  end

endmodule
